// File: rtl/riscv_mpsoc_pkg.sv
// Shared types for the data-memory arbiter: FSM states, well-known requester
// indices and the round-robin pointer advance.
package riscv_mpsoc_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   localparam int ARB_LSU = 0;
   localparam int ARB_PTW = 1;

   // Requester that gets first look after `cur` has been served.
   function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/riscv_dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// Handshake: a requester holds req (and its adr/we/be/d) until ack or err pulses
// for it; the arbiter holds mem_req and mem_* stable until mem_ack or mem_err.
interface riscv_dmem_arbiter_if #(
   parameter int XLEN = 64,
   parameter int NREQ = 2
);
   logic [NREQ-1:0]                 req;
   logic [NREQ-1:0]                 kill;
   logic [NREQ-1:0]                 lock;
   logic [NREQ-1:0][XLEN-1:0]       adr;
   logic [NREQ-1:0]                 we;
   logic [NREQ-1:0][XLEN/8-1:0]     be;
   logic [NREQ-1:0][XLEN-1:0]       d;
   logic [NREQ-1:0]                 ack;
   logic [NREQ-1:0]                 err;
   logic [XLEN-1:0]                 q;

   logic                            mem_req;
   logic [XLEN-1:0]                 mem_adr;
   logic                            mem_we;
   logic [XLEN/8-1:0]               mem_be;
   logic [XLEN-1:0]                 mem_d;
   logic                            mem_ack;
   logic                            mem_err;
   logic [XLEN-1:0]                 mem_q;

   modport slave (
      input  req, kill, lock, adr, we, be, d, mem_ack, mem_err, mem_q,
      output ack, err, q, mem_req, mem_adr, mem_we, mem_be, mem_d
   );

   modport master (
      output req, kill, lock, adr, we, be, d, mem_ack, mem_err, mem_q,
      input  ack, err, q, mem_req, mem_adr, mem_we, mem_be, mem_d
   );

endinterface

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module riscv_rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);

   logic hit;

   // Later writes win: the wrapped region is scanned first so any candidate
   // at or after ptr overrides it, and each scan ends on its lowest index.
   always_comb begin
      idx = '0;
      hit = 1'b0;
      for (int c = NREQ - 1; c >= 0; c--) begin
         if (req[c] && (IW'(c) < ptr)) begin
            idx = IW'(c);
            hit = 1'b1;
         end
      end
      for (int c = NREQ - 1; c >= 0; c--) begin
         if (req[c] && (IW'(c) >= ptr)) begin
            idx = IW'(c);
            hit = 1'b1;
         end
      end
      grant = '0;
      if (hit) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Shares the single data-memory port between NREQ requesters: round-robin,
// one outstanding transaction, per-requester kill and lock for atomics.
module riscv_dmem_arbiter
   import riscv_mpsoc_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int NREQ = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   riscv_dmem_arbiter_if.slave bus,
   output arb_state_e          dbg_state
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = XLEN / 8;

   arb_state_e      state;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   rr_ptr;
   logic            lock_held;
   logic            killed;

   logic            mem_req;
   logic [XLEN-1:0] mem_adr;
   logic            mem_we;
   logic [BW-1:0]   mem_be;
   logic [XLEN-1:0] mem_d;
   logic [NREQ-1:0] ack;
   logic [NREQ-1:0] err;
   logic [XLEN-1:0] q;

   logic [NREQ-1:0] owner_oh;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            lock_active;
   logic            kill_owner_now;

   always_comb begin
      owner_oh        = '0;
      owner_oh[owner] = 1'b1;
   end

   // A held lock is released in IDLE as soon as the owner drops lock or is flushed.
   assign lock_active    = lock_held & bus.lock[owner] & ~bus.kill[owner];
   assign eligible       = bus.req & ~bus.kill & (lock_active ? owner_oh : {NREQ{1'b1}});
   assign kill_owner_now = killed | bus.kill[owner];

   riscv_rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ARB_IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         lock_held <= 1'b0;
         killed    <= 1'b0;
         mem_req   <= 1'b0;
         mem_adr   <= '0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_d     <= '0;
         ack       <= '0;
         err       <= '0;
         q         <= '0;
      end else begin
         ack <= '0;
         err <= '0;
         unique case (state)
            ARB_IDLE: begin
               if (lock_held && !lock_active) lock_held <= 1'b0;
               if (|pick_grant) begin
                  owner   <= pick_idx;
                  mem_adr <= bus.adr[pick_idx];
                  mem_we  <= bus.we[pick_idx];
                  mem_be  <= bus.be[pick_idx];
                  mem_d   <= bus.d[pick_idx];
                  mem_req <= 1'b1;
                  state   <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               // The bus transfer always runs to completion; a flush only mutes the reply.
               if (bus.kill[owner]) killed <= 1'b1;
               if (bus.mem_ack || bus.mem_err) begin
                  mem_req <= 1'b0;
                  q       <= bus.mem_q;
                  state   <= ARB_RESP;
                  if (!kill_owner_now) begin
                     err[owner] <= bus.mem_err;
                     ack[owner] <= ~bus.mem_err;
                  end
               end
            end
            ARB_RESP: begin
               state     <= ARB_IDLE;
               killed    <= 1'b0;
               rr_ptr    <= IW'(rr_next(32'(owner), NREQ));
               lock_held <= bus.lock[owner] & ~killed;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign bus.mem_req = mem_req;
   assign bus.mem_adr = mem_adr;
   assign bus.mem_we  = mem_we;
   assign bus.mem_be  = mem_be;
   assign bus.mem_d   = mem_d;
   assign bus.ack     = ack;
   assign bus.err     = err;
   assign bus.q       = q;
   assign dbg_state   = state;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed scenarios with literal expectations,
// then randomized requesters/memory checked every cycle against a transaction model.
module tb_riscv_dmem_arbiter;
   import riscv_mpsoc_pkg::*;

   localparam int XLEN = 64;
   localparam int NREQ = 2;
   localparam int BW   = XLEN / 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   arb_state_e dbg_state;

   riscv_dmem_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

   riscv_dmem_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [XLEN-1:0] exp_q[$];

   // transaction-level model
   bit              m_busy, m_resp, m_killed, m_lock;
   int              m_owner, m_rr;
   logic            exp_mem_req;
   logic [XLEN-1:0] exp_adr, exp_d, exp_qd;
   logic            exp_we;
   logic [BW-1:0]   exp_be;
   logic [NREQ-1:0] exp_ack, exp_err;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_resp = 0; m_killed = 0; m_lock = 0;
      m_owner = 0; m_rr = 0;
      exp_mem_req = 0; exp_adr = '0; exp_d = '0; exp_qd = '0;
      exp_we = 0; exp_be = '0; exp_ack = '0; exp_err = '0;
   endtask

   // Given the inputs present this cycle, what the outputs must be after the next edge.
   task automatic model_predict();
      int pick;
      exp_ack = '0;
      exp_err = '0;
      if (m_resp) begin
         m_resp   = 0;
         m_rr     = (m_owner + 1) % NREQ;
         m_lock   = bus.lock[m_owner] && !m_killed;
         m_killed = 0;
      end else if (m_busy) begin
         if (bus.kill[m_owner]) m_killed = 1;
         if (bus.mem_ack || bus.mem_err) begin
            m_busy = 0; m_resp = 1; exp_mem_req = 0; exp_qd = bus.mem_q;
            if (!m_killed) begin
               if (bus.mem_err) exp_err[m_owner] = 1'b1;
               else exp_ack[m_owner] = 1'b1;
            end
         end
      end else begin
         if (m_lock && (!bus.lock[m_owner] || bus.kill[m_owner])) m_lock = 0;
         pick = -1;
         for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_rr + k) % NREQ;
            if (pick < 0 && bus.req[c] && !bus.kill[c] && (!m_lock || c == m_owner)) pick = c;
         end
         if (pick >= 0) begin
            m_owner = pick; m_busy = 1; m_killed = 0;
            exp_mem_req = 1;
            exp_adr = bus.adr[pick]; exp_we = bus.we[pick];
            exp_be  = bus.be[pick];  exp_d  = bus.d[pick];
         end
      end
   endtask

   task automatic compare();
      chk("mem_req", bus.mem_req, exp_mem_req);
      chk("ack", bus.ack, exp_ack);
      chk("err", bus.err, exp_err);
      chk("q", bus.q, exp_qd);
      if (exp_mem_req) begin
         chk("mem_adr", bus.mem_adr, exp_adr);
         chk("mem_we", bus.mem_we, exp_we);
         chk("mem_be", bus.mem_be, exp_be);
         chk("mem_d", bus.mem_d, exp_d);
      end
   endtask

   task automatic step();
      model_predict();
      @(negedge clk);
      compare();
   endtask

   task automatic clear_inputs();
      bus.req = '0; bus.kill = '0; bus.lock = '0; bus.we = '0;
      bus.adr = '0; bus.be = '0; bus.d = '0;
      bus.mem_ack = 0; bus.mem_err = 0; bus.mem_q = '0;
   endtask

   // One transaction from grant to the end of the response cycle.
   task automatic do_tx(input string tag, input int lat, input bit e, input logic [XLEN-1:0] qv,
                        input int who, input logic [NREQ-1:0] req_after, input logic [NREQ-1:0] lock_after);
      logic [XLEN-1:0] want_adr;
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[who] = 1'b1;
      want_adr = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      step();
      chk({tag, "_grant_adr"}, bus.mem_adr, want_adr);
      chk({tag, "_grant_req"}, bus.mem_req, 1'b1);
      repeat (lat) step();
      bus.mem_ack = 1; bus.mem_err = e; bus.mem_q = qv;
      step();
      chk({tag, "_ack"}, bus.ack, e ? '0 : oh);
      chk({tag, "_err"}, bus.err, e ? oh : '0);
      chk({tag, "_q"}, bus.q, qv);
      bus.mem_ack = 0; bus.mem_err = 0;
      bus.req = req_after; bus.lock = lock_after;
      step();
      chk({tag, "_pulse_end"}, bus.ack | bus.err, '0);
   endtask

   localparam logic [XLEN-1:0] A0 = 64'h0000_0000_8000_0100;
   localparam logic [XLEN-1:0] A1 = 64'h0000_0000_9000_0200;

   initial begin
      clear_inputs();
      model_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_mem_adr", bus.mem_adr, '0);
      chk("rst_ack", bus.ack, '0);
      chk("rst_err", bus.err, '0);
      chk("rst_q", bus.q, '0);
      chk("rst_state", dbg_state, ARB_IDLE);
      rst_n = 1;
      step();

      // LSU read with a two-cycle downstream latency
      bus.req[0] = 1; bus.adr[0] = 64'h8000_0010; bus.we[0] = 0; bus.be[0] = '1;
      step();
      chk("t1_req_latency", bus.mem_req, 1'b1);
      chk("t1_adr", bus.mem_adr, 64'h8000_0010);
      chk("t1_we", bus.mem_we, 1'b0);
      step();
      step();
      bus.mem_ack = 1; bus.mem_q = 64'hDEAD;
      step();
      chk("t1_ack", bus.ack, 2'b01);
      chk("t1_q", bus.q, 64'hDEAD);
      chk("t1_mem_req_drop", bus.mem_req, 1'b0);
      bus.mem_ack = 0; bus.req = '0;
      step();
      chk("t1_ack_one_cycle", bus.ack, 2'b00);
      chk("t1_q_hold", bus.q, 64'hDEAD);

      // ack and err together: err wins
      bus.req = 2'b10; bus.adr[1] = A1; bus.we[1] = 1; bus.d[1] = 64'h1234; bus.be[1] = 8'h0F;
      bus.adr[0] = A0;
      exp_q.push_back(A1);
      do_tx("t4", 1, 1'b1, 64'h55, 1, 2'b00, 2'b00);

      // both requesting continuously: strict alternation starting at 0
      bus.req = 2'b11;
      exp_q.push_back(A0); exp_q.push_back(A1); exp_q.push_back(A0); exp_q.push_back(A1);
      do_tx("t2a", 0, 1'b0, 64'h10, 0, 2'b11, 2'b00);
      do_tx("t2b", 2, 1'b0, 64'h11, 1, 2'b11, 2'b00);
      do_tx("t2c", 1, 1'b0, 64'h12, 0, 2'b11, 2'b00);
      do_tx("t2d", 0, 1'b0, 64'h13, 1, 2'b11, 2'b00);

      // owner flushed mid-transfer: reply is swallowed, requester 1 goes next
      exp_q.push_back(A0);
      step();
      chk("t3_grant0", bus.mem_adr, exp_q.pop_front());
      bus.kill[0] = 1; bus.req[0] = 0;
      step();
      bus.kill[0] = 0; bus.mem_ack = 1; bus.mem_q = 64'h77;
      step();
      chk("t3_no_ack", bus.ack, 2'b00);
      chk("t3_q_still_updates", bus.q, 64'h77);
      bus.mem_ack = 0;
      step();
      exp_q.push_back(A1);
      do_tx("t3b", 0, 1'b0, 64'h78, 1, 2'b00, 2'b00);

      // lock keeps requester 1 as owner until it drops lock
      bus.req = 2'b10; bus.lock = 2'b10;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(A1);
         do_tx($sformatf("t5_lock%0d", k), k % 2, 1'b0, 64'(k), 1, 2'b11, (k < 3) ? 2'b10 : 2'b00);
      end
      exp_q.push_back(A0);
      do_tx("t5_release", 0, 1'b0, 64'hAA, 0, 2'b10, 2'b00);

      // reset while the bus is busy
      step();
      chk("t6_busy", bus.mem_req, 1'b1);
      step();
      #2 rst_n = 0;
      #1;
      chk("t6_async_mem_req", bus.mem_req, 1'b0);
      chk("t6_async_ack", bus.ack | bus.err, '0);
      chk("t6_async_q", bus.q, '0);
      model_reset();
      bus.req = '0; bus.mem_ack = 1; bus.mem_q = 64'hBAD;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      step();
      bus.mem_ack = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t6_no_rsp", bus.ack | bus.err, '0);
      end

      // randomized requesters and memory
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            bus.kill[i] = 0;
            if (bus.req[i] && (exp_ack[i] || exp_err[i])) begin
               bus.req[i] = 0;
            end else if (bus.req[i] && $urandom_range(0, 39) == 0) begin
               bus.req[i] = 0; bus.kill[i] = 1;
            end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
               bus.req[i] = 1;
               bus.adr[i] = {$urandom, $urandom};
               bus.d[i]   = {$urandom, $urandom};
               bus.we[i]  = 1'($urandom);
               bus.be[i]  = 8'($urandom);
            end
            if ($urandom_range(0, 15) == 0) bus.lock[i] = ~bus.lock[i];
         end
         bus.mem_ack = 0; bus.mem_err = 0;
         if (m_busy && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 5))
               0:       bus.mem_err = 1;
               1:       begin bus.mem_err = 1; bus.mem_ack = 1; end
               default: bus.mem_ack = 1;
            endcase
         end
         bus.mem_q = {$urandom, $urandom};
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
